// File: rtl/dbfs_mul_pipe.sv
// dbfs_mul_pipe
//   Pipelined multiplier for the dbfs datapath. Each operand is sign- or
//   zero-extended, multiplied exactly, optionally round-shifted right, then
//   range checked and either clamped or wrapped to DOUT_WIDTH bits. Overflow
//   events are counted in a saturating 16-bit counter.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   ce         clock enable; 0 freezes every register except the ovf_clr path
//   in_valid   din0/din1 valid this cycle
//   din0/din1  operands
//   ovf_clr    synchronous clear of ovf_count, independent of ce
//   out_valid  dout/ovf valid (NUM_STAGE ce cycles after acceptance)
//   dout       result
//   ovf        result was out of range, aligned with out_valid
//   ovf_count  number of overflowing results (saturates at 0xFFFF)
module dbfs_mul_pipe #(
  parameter int DIN0_WIDTH  = 30,
  parameter int DIN1_WIDTH  = 6,
  parameter int DOUT_WIDTH  = 36,
  parameter int NUM_STAGE   = 2,
  parameter int DIN0_SIGNED = 0,
  parameter int DIN1_SIGNED = 0,
  parameter int OUT_SHIFT   = 0,
  parameter int SATURATE    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic                  ovf_clr,
  output logic                  out_valid,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  ovf,
  output logic [15:0]           ovf_count
);

  // PW holds the exact product of either signedness; RW adds headroom for
  // the rounding constant; CW can hold both R and the output bounds.
  localparam int PW = DIN0_WIDTH + DIN1_WIDTH + 1;
  localparam int RW = PW + 1;
  localparam int CW = ((RW > DOUT_WIDTH + 1) ? RW : DOUT_WIDTH + 1) + 1;
  localparam bit RES_SIGNED = (DIN0_SIGNED != 0) || (DIN1_SIGNED != 0);

  localparam logic signed [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic signed [CW-1:0] HI  = RES_SIGNED ? ((ONE <<< (DOUT_WIDTH-1)) - ONE)
                                                    : ((ONE <<< DOUT_WIDTH) - ONE);
  localparam logic signed [CW-1:0] LO  = RES_SIGNED ? -(ONE <<< (DOUT_WIDTH-1))
                                                    : {CW{1'b0}};

  // ---------------------------------------------------------------- product
  logic               s0, s1;
  logic signed [PW-1:0] a_ext, b_ext, prod;

  assign s0    = (DIN0_SIGNED != 0) ? din0[DIN0_WIDTH-1] : 1'b0;
  assign s1    = (DIN1_SIGNED != 0) ? din1[DIN1_WIDTH-1] : 1'b0;
  assign a_ext = {{(PW-DIN0_WIDTH){s0}}, din0};
  assign b_ext = {{(PW-DIN1_WIDTH){s1}}, din1};
  assign prod  = a_ext * b_ext;

  // ------------------------------------------------------------- pipeline
  // The multiply is absorbed into the first stage; the remaining NUM_STAGE-1
  // stages carry the product, and round/range/clamp sits in front of the
  // output register, so observable latency is exactly NUM_STAGE.
  logic signed [PW-1:0] p_last;
  logic                 v_last;

  generate
    if (NUM_STAGE == 1) begin : g_nopipe
      assign p_last = prod;
      assign v_last = in_valid;
    end else begin : g_pipe
      logic signed [PW-1:0] p_q [NUM_STAGE-1];
      logic [NUM_STAGE-2:0] vld_pipe;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < NUM_STAGE-1; i++) p_q[i] <= '0;
          vld_pipe <= '0;
        end else if (ce) begin
          p_q[0]      <= prod;
          vld_pipe[0] <= in_valid;
          for (int i = 1; i < NUM_STAGE-1; i++) begin
            p_q[i]      <= p_q[i-1];
            vld_pipe[i] <= vld_pipe[i-1];
          end
        end
      end

      assign p_last = p_q[NUM_STAGE-2];
      assign v_last = vld_pipe[NUM_STAGE-2];
    end
  endgenerate

  // ------------------------------------------------------------- rounding
  logic signed [RW-1:0] r_w;

  generate
    if (OUT_SHIFT > 0) begin : g_rnd
      localparam logic signed [RW-1:0] HALF = {{(RW-1){1'b0}}, 1'b1} << (OUT_SHIFT-1);
      logic signed [RW-1:0] sum;
      // Half-LSB bias then arithmetic shift: round half toward +inf.
      assign sum = {p_last[PW-1], p_last} + HALF;
      assign r_w = sum >>> OUT_SHIFT;
    end else begin : g_nornd
      assign r_w = {p_last[PW-1], p_last};
    end
  endgenerate

  // ---------------------------------------------------------- range check
  logic signed [CW-1:0] r_c;
  logic [DOUT_WIDTH-1:0] dout_d;
  logic                  ovf_d;
  logic                  over, under;

  assign r_c = {{(CW-RW){r_w[RW-1]}}, r_w};

  always_comb begin
    over   = (r_c > HI);
    under  = (r_c < LO);
    ovf_d  = over || under;
    dout_d = r_c[DOUT_WIDTH-1:0];
    if (SATURATE != 0) begin
      if (over)       dout_d = HI[DOUT_WIDTH-1:0];
      else if (under) dout_d = LO[DOUT_WIDTH-1:0];
    end
  end

  // ------------------------------------------------------- output register
  logic                  out_valid_q, ovf_q;
  logic [DOUT_WIDTH-1:0] dout_q;
  logic [15:0]           ovf_count_q, ovf_count_d;

  // Clear beats a coincident increment; the counter sticks at all-ones.
  always_comb begin
    ovf_count_d = ovf_count_q;
    if (ovf_clr)
      ovf_count_d = '0;
    else if (ce && v_last && ovf_d && (ovf_count_q != 16'hFFFF))
      ovf_count_d = ovf_count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      ovf_q       <= 1'b0;
      ovf_count_q <= '0;
    end else begin
      ovf_count_q <= ovf_count_d;
      if (ce) begin
        out_valid_q <= v_last;
        // Bubbles leave the previous result on dout.
        if (v_last) begin
          dout_q <= dout_d;
          ovf_q  <= ovf_d;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign ovf       = ovf_q;
  assign ovf_count = ovf_count_q;

endmodule

// File: tb/tb_dbfs_mul_pipe.sv
// Scoreboard bench for dbfs_mul_pipe. Six instances cover the default
// config, signed saturate/wrap, unsigned/signed rounding and a deep pipe
// used for the mid-flight reset. Stimulus pushes hand-computed expectations
// per instance; a negedge monitor pops one entry per newly loaded result.
module tb_dbfs_mul_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [5:0] rst, ce, iv, clr, ov, of, ce_s;
  logic [29:0] a0;
  logic [5:0]  a1;
  logic [7:0]  b0, b1, d0, d1, e0, e1;
  logic [35:0] doA, doF;
  logic [7:0]  doB, doC;
  logic [15:0] doD, doE;
  logic [15:0] cnt [6];
  logic [63:0] got_d [6];

  int checks = 0;
  int errors = 0;
  int bubbles = 0;
  logic [64:0] expq [6][$];
  logic [64:0] e;

  assign got_d[0] = {28'b0, doA};
  assign got_d[1] = {56'b0, doB};
  assign got_d[2] = {56'b0, doC};
  assign got_d[3] = {48'b0, doD};
  assign got_d[4] = {48'b0, doE};
  assign got_d[5] = {28'b0, doF};

  dbfs_mul_pipe u_a (
    .clk(clk), .reset(rst[0]), .ce(ce[0]), .in_valid(iv[0]), .din0(a0), .din1(a1),
    .ovf_clr(clr[0]), .out_valid(ov[0]), .dout(doA), .ovf(of[0]), .ovf_count(cnt[0]));

  dbfs_mul_pipe #(.DIN0_WIDTH(8), .DIN1_WIDTH(8), .DOUT_WIDTH(8), .DIN0_SIGNED(1),
                  .DIN1_SIGNED(1), .SATURATE(1)) u_b (
    .clk(clk), .reset(rst[1]), .ce(ce[1]), .in_valid(iv[1]), .din0(b0), .din1(b1),
    .ovf_clr(clr[1]), .out_valid(ov[1]), .dout(doB), .ovf(of[1]), .ovf_count(cnt[1]));

  dbfs_mul_pipe #(.DIN0_WIDTH(8), .DIN1_WIDTH(8), .DOUT_WIDTH(8), .DIN0_SIGNED(1),
                  .DIN1_SIGNED(1), .SATURATE(0)) u_c (
    .clk(clk), .reset(rst[2]), .ce(ce[2]), .in_valid(iv[2]), .din0(b0), .din1(b1),
    .ovf_clr(clr[2]), .out_valid(ov[2]), .dout(doC), .ovf(of[2]), .ovf_count(cnt[2]));

  dbfs_mul_pipe #(.DIN0_WIDTH(8), .DIN1_WIDTH(8), .DOUT_WIDTH(16), .OUT_SHIFT(4)) u_d (
    .clk(clk), .reset(rst[3]), .ce(ce[3]), .in_valid(iv[3]), .din0(d0), .din1(d1),
    .ovf_clr(clr[3]), .out_valid(ov[3]), .dout(doD), .ovf(of[3]), .ovf_count(cnt[3]));

  dbfs_mul_pipe #(.DIN0_WIDTH(8), .DIN1_WIDTH(8), .DOUT_WIDTH(16), .OUT_SHIFT(4),
                  .DIN0_SIGNED(1), .DIN1_SIGNED(1)) u_e (
    .clk(clk), .reset(rst[4]), .ce(ce[4]), .in_valid(iv[4]), .din0(e0), .din1(e1),
    .ovf_clr(clr[4]), .out_valid(ov[4]), .dout(doE), .ovf(of[4]), .ovf_count(cnt[4]));

  dbfs_mul_pipe #(.NUM_STAGE(4)) u_f (
    .clk(clk), .reset(rst[5]), .ce(ce[5]), .in_valid(iv[5]), .din0(a0), .din1(a1),
    .ovf_clr(clr[5]), .out_valid(ov[5]), .dout(doF), .ovf(of[5]), .ovf_count(cnt[5]));

  // ce seen by the last edge: a held out_valid under ce=0 is not a new result
  always @(posedge clk) ce_s <= ce;

  always @(negedge clk) begin
    for (int k = 0; k < 6; k++) begin
      if (ce_s[k] && ov[k]) begin
        checks++;
        if (expq[k].size() == 0) begin
          errors++;
          $display("FAIL unexpected_out inst=%0d got dout=%0h, none expected", k, got_d[k]);
        end else begin
          e = expq[k].pop_front();
          if (got_d[k] !== e[63:0] || of[k] !== e[64]) begin
            errors++;
            $display("FAIL sb inst=%0d got dout=%0h ovf=%0b exp dout=%0h ovf=%0b",
                     k, got_d[k], of[k], e[63:0], e[64]);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic push(input int k, input logic [63:0] d, input logic o);
    expq[k].push_back({o, d});
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = '1; ce = '1; iv = '0; clr = '0;
    a0 = '0; a1 = '0; b0 = '0; b1 = '0; d0 = '0; d1 = '0; e0 = '0; e1 = '0;
    cyc(2);
    for (int k = 0; k < 6; k++) begin
      chk("rst_valid", {63'b0, ov[k]}, 0);
      chk("rst_dout", got_d[k], 0);
      chk("rst_ovf", {63'b0, of[k]}, 0);
      chk("rst_cnt", {48'b0, cnt[k]}, 0);
    end
    rst = '0;
    cyc(2);

    // ---- defaults: latency 2, max operands
    iv[0] = 1; a0 = 30'd1000; a1 = 6'd63; push(0, 64'd63000, 0);
    cyc; chk("lat_edge1_valid", {63'b0, ov[0]}, 0);
    a0 = 30'h3FFFFFFF; a1 = 6'd63; push(0, 64'd67645734849, 0);
    cyc; chk("lat_edge2_valid", {63'b0, ov[0]}, 1);
    iv[0] = 0;
    cyc(3);

    // ---- ce stall
    a0 = 30'd5; a1 = 6'd7; iv[0] = 1; push(0, 64'd35, 0);
    cyc; iv[0] = 0; ce[0] = 0;
    for (int i = 0; i < 3; i++) begin
      cyc;
      chk("stall_valid", {63'b0, ov[0]}, 0);
      chk("stall_dout_frozen", got_d[0], 64'd67645734849);
    end
    ce[0] = 1;
    cyc; chk("stall_out_valid", {63'b0, ov[0]}, 1); chk("stall_out_dout", got_d[0], 64'd35);
    ce[0] = 0;
    cyc(2); chk("hold_valid", {63'b0, ov[0]}, 1); chk("hold_dout", got_d[0], 64'd35);
    ce[0] = 1;
    cyc; chk("bubble_valid", {63'b0, ov[0]}, 0); chk("bubble_dout_hold", got_d[0], 64'd35);

    // ---- signed 8x8 -> 8: saturate (B) and wrap (C)
    iv[2:1] = 2'b11;
    b0 = 8'h80; b1 = 8'h80; push(1, 64'h7F, 1); push(2, 64'h00, 1); cyc;
    b0 = 8'h80; b1 = 8'h7F; push(1, 64'h80, 1); push(2, 64'h80, 1); cyc;
    b0 = 8'd3;  b1 = 8'hFB; push(1, 64'hF1, 0); push(2, 64'hF1, 0); cyc;
    iv[2:1] = 2'b00;
    cyc(3);
    chk("cnt_B_after_sat", {48'b0, cnt[1]}, 2);
    chk("cnt_C_after_wrap", {48'b0, cnt[2]}, 2);

    // ---- rounding, shift 4: unsigned (D) and signed (E)
    iv[4:3] = 2'b11;
    d0 = 8'd4;   d1 = 8'd6;   push(3, 64'd2, 0);      e0 = 8'd4;  e1 = 8'hFA; push(4, 64'hFFFF, 0); cyc;
    d0 = 8'd1;   d1 = 8'd23;  push(3, 64'd1, 0);      e0 = 8'd5;  e1 = 8'hFB; push(4, 64'hFFFE, 0); cyc;
    d0 = 8'd255; d1 = 8'd255; push(3, 64'h0FE0, 0);   e0 = 8'h80; e1 = 8'h80; push(4, 64'h0400, 0); cyc;
    d0 = 8'd1;   d1 = 8'd8;   push(3, 64'd1, 0);      e0 = 8'd1;  e1 = 8'hF8; push(4, 64'h0000, 0); cyc;
    iv[4:3] = 2'b00;
    cyc(3);

    // ---- mid-flight reset on the 4-stage instance
    for (int i = 1; i <= 4; i++) begin
      iv[5] = 1; a0 = 30'(i); a1 = 6'd2;
      if (i <= 2) push(5, 64'(2 * i), 0);
      cyc;
    end
    iv[5] = 0;
    cyc;                         // second result lands on this edge
    #2 rst[5] = 1;
    #1 chk("rst_mid_valid", {63'b0, ov[5]}, 0);
    chk("rst_mid_dout", got_d[5], 0);
    cyc; rst[5] = 0;
    for (int i = 0; i < 6; i++) begin
      cyc; chk("post_rst_idle", {63'b0, ov[5]}, 0);
    end
    iv[5] = 1; a0 = 30'd3; a1 = 6'd3; push(5, 64'd9, 0);
    cyc; iv[5] = 0;
    cyc(2); chk("post_rst_lat3", {63'b0, ov[5]}, 0);
    cyc;    chk("post_rst_lat4", {63'b0, ov[5]}, 1);
    cyc(2);

    // ---- counter saturation with a continuous overflow stream
    iv[2:1] = 2'b11; b0 = 8'h80; b1 = 8'h80;
    for (int i = 0; i < 70000; i++) begin
      push(1, 64'h7F, 1); push(2, 64'h00, 1);
      cyc;
      if (i >= 2 && !ov[1]) bubbles++;
    end
    iv[2:1] = 2'b00;
    cyc(3);
    chk("no_bubbles", 64'(bubbles), 0);
    chk("cnt_B_sat", {48'b0, cnt[1]}, 65535);
    chk("cnt_C_sat", {48'b0, cnt[2]}, 65535);

    // clear coinciding with an overflowing load on B
    iv[2:1] = 2'b11; push(1, 64'h7F, 1); push(2, 64'h00, 1);
    cyc; iv[2:1] = 2'b00; clr[1] = 1;
    cyc; clr[1] = 0;
    chk("clr_wins", {48'b0, cnt[1]}, 0);
    chk("cnt_C_still_sat", {48'b0, cnt[2]}, 65535);
    iv[1] = 1; push(1, 64'h7F, 1);
    cyc; iv[1] = 0;
    cyc; chk("cnt_after_clr_inc", {48'b0, cnt[1]}, 1);

    // clear works with ce low
    ce[2] = 0; clr[2] = 1;
    cyc; clr[2] = 0;
    chk("clr_ce_low", {48'b0, cnt[2]}, 0);
    ce[2] = 1;
    cyc(3);

    for (int k = 0; k < 6; k++) chk("drain", 64'(expq[k].size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
